list_walk_engine: RTL

//  Parametrised linked-list reduction engine; successor to the fixed 8-bit list summer.

---
 rtl/list_walk_if.sv | 27 ++
 rtl/list_walk_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/list_walk_if.sv
// Bus bundle for list_walk_engine: control handshake, result reporting and memory read port.
interface list_walk_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 8
);
   logic          start;
   logic [AW-1:0] head;
   logic [1:0]    mode;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [DW-1:0] mem_data;
   logic          busy;
   logic          done;
   logic [DW-1:0] result;
   logic          ovf;
   logic          err;

   modport master (
      output start, head, mode, mem_data,
      input  mem_addr, mem_rd, busy, done, result, ovf, err
   );

   modport slave (
      input  start, head, mode, mem_data,
      output mem_addr, mem_rd, busy, done, result, ovf, err
   );
endinterface

// File: rtl/list_walk_engine.sv
// Linked-list reduction engine (SUM / COUNT / MAX) with overflow and runaway-list detection.
// Optional macro LIST_SAT_EN: SUM and COUNT saturate at all-ones instead of wrapping.
module list_walk_engine #(
   parameter int unsigned DW        = 8,
   parameter int unsigned AW        = 8,
   parameter int unsigned MAX_NODES = 255
) (
   input logic        clk,
   input logic        rst,
   list_walk_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_LINK, S_DONE} state_t;
   typedef enum logic [1:0] {M_SUM, M_COUNT, M_MAX, M_RSVD} mode_t;

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] result_q, result_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic [DW-1:0] addend;
   logic [DW:0]   acc_sum;
   logic [DW-1:0] acc_val;
   logic [AW-1:0] nxt;

   // COUNT reuses the adder with a constant increment so both share carry/saturation handling
   always_comb begin
      addend  = (mode_q == M_COUNT) ? DW'(1) : bus.mem_data;
      acc_sum = {1'b0, result_q} + {1'b0, addend};
`ifdef LIST_SAT_EN
      acc_val = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
`else
      acc_val = acc_sum[DW-1:0];
`endif
   end

   assign nxt = bus.mem_data[AW-1:0];

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      ovf_d        = ovf_q;
      err_d        = err_q;
      bus.mem_addr = '0;
      bus.mem_rd   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               mode_d   = mode_t'(bus.mode);
               ptr_d    = bus.head;
               cnt_d    = '0;
               result_d = '0;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
               state_d  = (bus.head == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            bus.mem_addr = ptr_q;
            bus.mem_rd   = 1'b1;
            state_d      = S_ACC;
         end
         S_ACC: begin
            if (mode_q == M_MAX) begin
               if (bus.mem_data > result_q) result_d = bus.mem_data;
            end else begin
               result_d = acc_val;
               ovf_d    = ovf_q | acc_sum[DW];
            end
            cnt_d        = cnt_q + AW'(1);
            bus.mem_addr = ptr_q + AW'(1);
            bus.mem_rd   = 1'b1;
            state_d      = S_LINK;
         end
         S_LINK: begin
            if (nxt == '0) begin
               state_d = S_DONE;
            end else if (cnt_q == AW'(MAX_NODES)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               // value read of the next node overlaps the link decision
               ptr_d        = nxt;
               bus.mem_addr = nxt;
               bus.mem_rd   = 1'b1;
               state_d      = S_ACC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= M_SUM;
         ptr_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign bus.busy   = (state_q == S_FETCH) || (state_q == S_ACC) || (state_q == S_LINK);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
   assign bus.err    = err_q;
endmodule
